// File: rtl/ni_apb_initiator_if.sv
// ni_apb_initiator_if
//   Bundles the APB completer signals and the router-port packet slots of one
//   initiator NI.
//
//   Handshake semantics:
//     APB side: a transfer starts with a setup phase (i_psel=1, i_penable=0).
//     The NI captures the request there and answers with a one-cycle
//     o_pready pulse. o_prdata/o_pslverr are valid only while o_pready=1.
//     Packet side: a packet is present in a cycle when its MSB (valid) is 1.
//     There is no backpressure. A packet is consumed in the cycle it is shown.
//
//   Modports:
//     slave  - the NI (APB completer, packet producer/consumer)
//     master - the APB requester plus router environment (testbench)
interface ni_apb_initiator_if #(
  parameter int GRID_WIDTH = 4
);
  localparam int CW = $clog2(GRID_WIDTH);
  localparam int PW = 43 + 4 * CW;

  logic          i_psel;
  logic          i_penable;
  logic          i_pwrite;
  logic [15:0]   i_paddr;
  logic [31:0]   i_pwdata;
  logic          o_pready;
  logic          o_pslverr;
  logic [31:0]   o_prdata;
  logic [PW-1:0] o_niToRouter;
  logic [PW-1:0] i_routerToNi;

  modport slave (
    input  i_psel, i_penable, i_pwrite, i_paddr, i_pwdata, i_routerToNi,
    output o_pready, o_pslverr, o_prdata, o_niToRouter
  );

  modport master (
    output i_psel, i_penable, i_pwrite, i_paddr, i_pwdata, i_routerToNi,
    input  o_pready, o_pslverr, o_prdata, o_niToRouter
  );
endinterface

// File: rtl/ni_apb_initiator.sv
// ni_apb_initiator
//   Initiator-side network interface of one mesh node. It accepts one APB
//   access and sends it as a request packet to the router. It then waits for
//   the matching response packet and completes the access. The access ends
//   with an error on timeout or on an out-of-grid destination.
//
//   Ports:
//     i_clk        clock
//     i_arst       asynchronous reset, active-high
//     io_apb       ni_apb_initiator_if.slave (APB completer + packet slots)
//     o_dbg_state  current FSM state (0 IDLE, 1 SEND, 2 WAIT, 3 DONE)
//
//   Packet layout, MSB first:
//     valid, isResp, write, dstX, dstY, srcX, srcY, addr[8], data[32]
module ni_apb_initiator #(
  parameter int GRID_WIDTH     = 4,
  parameter int NODE_X         = 0,
  parameter int NODE_Y         = 0,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                i_clk,
  input  logic                i_arst,
  ni_apb_initiator_if.slave   io_apb,
  output logic [1:0]          o_dbg_state
);

  localparam int CW = $clog2(GRID_WIDTH);
  localparam int PW = 43 + 4 * CW;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CW-1:0] OWN_X    = CW'(NODE_X);
  localparam logic [CW-1:0] OWN_Y    = CW'(NODE_Y);
  localparam logic [CW:0]   GRID_LIM = (CW + 1)'(GRID_WIDTH);
  localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t        r_state;
  logic [TW-1:0] r_cnt;
  logic [CW-1:0] r_dst_x;
  logic [CW-1:0] r_dst_y;
  logic          r_write;
  logic [PW-1:0] r_pkt;
  logic          r_pready;
  logic          r_pslverr;
  logic [31:0]   r_prdata;

  // Setup-phase decode of the APB address.
  logic          w_setup;
  logic [CW-1:0] w_dst_x;
  logic [CW-1:0] w_dst_y;
  logic          w_bad_dst;
  logic [PW-1:0] w_req_pkt;

  assign w_setup   = io_apb.i_psel & ~io_apb.i_penable;
  assign w_dst_x   = io_apb.i_paddr[8 +: CW];
  assign w_dst_y   = io_apb.i_paddr[8 + CW +: CW];
  assign w_bad_dst = ({1'b0, w_dst_x} >= GRID_LIM) |
                     ({1'b0, w_dst_y} >= GRID_LIM);
  assign w_req_pkt = {1'b1, 1'b0, io_apb.i_pwrite, w_dst_x, w_dst_y,
                      OWN_X, OWN_Y, io_apb.i_paddr[7:0],
                      io_apb.i_pwrite ? io_apb.i_pwdata : 32'h0};

  // Incoming packet fields.
  logic [PW-1:0] w_rx;
  logic          w_rx_valid;
  logic          w_rx_resp;
  logic [CW-1:0] w_rx_dst_x;
  logic [CW-1:0] w_rx_dst_y;
  logic [CW-1:0] w_rx_src_x;
  logic [CW-1:0] w_rx_src_y;
  logic [31:0]   w_rx_data;
  logic          w_match;

  assign w_rx       = io_apb.i_routerToNi;
  assign w_rx_valid = w_rx[PW-1];
  assign w_rx_resp  = w_rx[PW-2];
  assign w_rx_dst_x = w_rx[40 + 3 * CW +: CW];
  assign w_rx_dst_y = w_rx[40 + 2 * CW +: CW];
  assign w_rx_src_x = w_rx[40 + CW +: CW];
  assign w_rx_src_y = w_rx[40 +: CW];
  assign w_rx_data  = w_rx[31:0];

  // A response for us must come from the node that we addressed.
  assign w_match = w_rx_valid & w_rx_resp &
                   (w_rx_dst_x == OWN_X) & (w_rx_dst_y == OWN_Y) &
                   (w_rx_src_x == r_dst_x) & (w_rx_src_y == r_dst_y);

  // Address bits above the destination fields, and the response write/addr
  // fields, carry no meaning here.
  logic w_unused;
  assign w_unused = ^{io_apb.i_paddr, w_rx};

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_dst_x   <= '0;
      r_dst_y   <= '0;
      r_write   <= 1'b0;
      r_pkt     <= '0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_prdata  <= '0;
    end else begin
      // The packet and the completion are single-cycle pulses. They are
      // cleared by default and set only on the transition that enters
      // SEND or DONE.
      r_pkt     <= '0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_prdata  <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_setup) begin
            r_write <= io_apb.i_pwrite;
            r_dst_x <= w_dst_x;
            r_dst_y <= w_dst_y;
            if (w_bad_dst) begin
              r_state   <= S_DONE;
              r_pready  <= 1'b1;
              r_pslverr <= 1'b1;
            end else begin
              r_state <= S_SEND;
              r_pkt   <= w_req_pkt;
            end
          end
        end
        S_SEND: begin
          r_state <= S_WAIT;
          r_cnt   <= '0;
        end
        S_WAIT: begin
          // A match takes priority over a timeout in the same cycle.
          if (w_match) begin
            r_state  <= S_DONE;
            r_pready <= 1'b1;
            r_prdata <= r_write ? 32'h0 : w_rx_data;
          end else if (r_cnt == CNT_LAST) begin
            r_state   <= S_DONE;
            r_pready  <= 1'b1;
            r_pslverr <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign io_apb.o_niToRouter = r_pkt;
  assign io_apb.o_pready     = r_pready;
  assign io_apb.o_pslverr    = r_pslverr;
  assign io_apb.o_prdata     = r_prdata;
  assign o_dbg_state         = r_state;

endmodule

// File: tb/tb_ni_apb_initiator.sv
// tb_ni_apb_initiator
//   Directed bench for ni_apb_initiator. DUT A has a 4x4 grid and DUT B has
//   a 3x3 grid. Both sit at node (0,0) with TIMEOUT_CYCLES=8. A vector table
//   holds one APB access, up to four injected router packets, the expected
//   request packet and the expected completion. A few hand-written sequences
//   cover reset behaviour.
module tb_ni_apb_initiator;

  localparam int PW  = 51;
  localparam int WIN = 20;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  ni_apb_initiator_if #(.GRID_WIDTH(4)) a_if ();
  ni_apb_initiator_if #(.GRID_WIDTH(3)) b_if ();
  logic [1:0] a_dbg, b_dbg;

  ni_apb_initiator #(.GRID_WIDTH(4), .NODE_X(0), .NODE_Y(0), .TIMEOUT_CYCLES(8)) u_dut_a (
    .i_clk(clk), .i_arst(rst), .io_apb(a_if.slave), .o_dbg_state(a_dbg)
  );
  ni_apb_initiator #(.GRID_WIDTH(3), .NODE_X(0), .NODE_Y(0), .TIMEOUT_CYCLES(8)) u_dut_b (
    .i_clk(clk), .i_arst(rst), .io_apb(b_if.slave), .o_dbg_state(b_dbg)
  );

  // Shared stimulus, routed to the selected DUT (sel=0: A, sel=1: B).
  logic          sel;
  logic          psel, penable, pwrite;
  logic [15:0]   paddr;
  logic [31:0]   pwdata;
  logic [PW-1:0] rsp;

  assign a_if.i_psel       = psel & ~sel;
  assign a_if.i_penable    = penable & ~sel;
  assign a_if.i_pwrite     = pwrite;
  assign a_if.i_paddr      = paddr;
  assign a_if.i_pwdata     = pwdata;
  assign a_if.i_routerToNi = sel ? '0 : rsp;
  assign b_if.i_psel       = psel & sel;
  assign b_if.i_penable    = penable & sel;
  assign b_if.i_pwrite     = pwrite;
  assign b_if.i_paddr      = paddr;
  assign b_if.i_pwdata     = pwdata;
  assign b_if.i_routerToNi = sel ? rsp : '0;

  logic          obs_pready, obs_pslverr;
  logic [31:0]   obs_prdata;
  logic [PW-1:0] obs_pkt;
  assign obs_pready  = sel ? b_if.o_pready     : a_if.o_pready;
  assign obs_pslverr = sel ? b_if.o_pslverr    : a_if.o_pslverr;
  assign obs_prdata  = sel ? b_if.o_prdata     : a_if.o_prdata;
  assign obs_pkt     = sel ? b_if.o_niToRouter : a_if.o_niToRouter;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act);
    logic [63:0] exp_v;
    exp_v = exp_q.pop_front();
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
    end
  endtask

  // Packet packing helper for CW=2.
  function automatic logic [PW-1:0] pk(input logic v, input logic r, input logic w,
                                       input logic [1:0] dx, input logic [1:0] dy,
                                       input logic [1:0] sx, input logic [1:0] sy,
                                       input logic [7:0] a, input logic [31:0] d);
    return {v, r, w, dx, dy, sx, sy, a, d};
  endfunction

  // ---------------- vector table ----------------
  localparam logic [4:0] NONE = 5'd31;

  typedef struct packed {
    logic          dut_b;
    logic          write;
    logic [15:0]   addr;
    logic [31:0]   wdata;
    logic [4:0]    e0, e1, e2, e3;     // edge at which packet pN is sampled
    logic [PW-1:0] p0, p1, p2, p3;
    logic [PW-1:0] exp_pkt;            // expected packet after setup edge
    logic [4:0]    exp_rdy_edge;       // edge after which pready is high
    logic          exp_slverr;
    logic [31:0]   exp_rdata;
  } vec_t;

  vec_t vecs[8];

  // ---------------- driver tasks ----------------
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    logic [PW-1:0] pkt0;
    int            other_nz, rdy_cnt, rdy_edge;
    logic          slv;
    logic [31:0]   rd;
    other_nz = 0; rdy_cnt = 0; rdy_edge = 99; slv = 1'b0; rd = '0; pkt0 = '0;
    sel     = v.dut_b;
    psel    = 1'b1;
    penable = 1'b0;
    pwrite  = v.write;
    paddr   = v.addr;
    pwdata  = v.wdata;
    rsp     = '0;
    for (int c = 0; c < WIN; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (c == 0) begin
        penable = 1'b1;
        pkt0    = obs_pkt;
      end else if (obs_pkt != '0) begin
        other_nz++;
      end
      if (obs_pready) begin
        rdy_cnt++;
        if (rdy_cnt == 1) begin
          rdy_edge = c;
          slv      = obs_pslverr;
          rd       = obs_prdata;
        end
        psel    = 1'b0;
        penable = 1'b0;
      end
      rsp = '0;
      if (v.e0 == 5'(c + 1)) rsp = v.p0;
      if (v.e1 == 5'(c + 1)) rsp = v.p1;
      if (v.e2 == 5'(c + 1)) rsp = v.p2;
      if (v.e3 == 5'(c + 1)) rsp = v.p3;
    end
    psel = 1'b0; penable = 1'b0; rsp = '0;
    exp_q.push_back(64'(v.exp_pkt));      chk($sformatf("v%0d_req_pkt", idx), 64'(pkt0));
    exp_q.push_back(64'd0);               chk($sformatf("v%0d_pkt_outside_send", idx), 64'(other_nz));
    exp_q.push_back(64'd1);               chk($sformatf("v%0d_pready_count", idx), 64'(rdy_cnt));
    exp_q.push_back(64'(v.exp_rdy_edge)); chk($sformatf("v%0d_pready_edge", idx), 64'(rdy_edge));
    exp_q.push_back(64'(v.exp_slverr));   chk($sformatf("v%0d_pslverr", idx), 64'(slv));
    exp_q.push_back(64'(v.exp_rdata));    chk($sformatf("v%0d_prdata", idx), 64'(rd));
    idle_cycles(2);
  endtask

  // ---------------- test ----------------
  initial begin
    // 0: read (2,2) addr 0x34, response sampled at edge 2 -> pready cycle 3
    vecs[0] = '{dut_b:1'b0, write:1'b0, addr:16'h0A34, wdata:32'hFFFF_FFFF,
                e0:5'd2, e1:NONE, e2:NONE, e3:NONE,
                p0:pk(1,1,0,2'd0,2'd0,2'd2,2'd2,8'h34,32'hDEAD_BEEF), p1:'0, p2:'0, p3:'0,
                exp_pkt:pk(1,0,0,2'd2,2'd2,2'd0,2'd0,8'h34,32'h0),
                exp_rdy_edge:5'd2, exp_slverr:1'b0, exp_rdata:32'hDEAD_BEEF};
    // 1: write (1,0), response data is not returned for writes
    vecs[1] = '{dut_b:1'b0, write:1'b1, addr:16'h0110, wdata:32'h1234_5678,
                e0:5'd3, e1:NONE, e2:NONE, e3:NONE,
                p0:pk(1,1,1,2'd0,2'd0,2'd1,2'd0,8'h10,32'hAAAA_5555), p1:'0, p2:'0, p3:'0,
                exp_pkt:pk(1,0,1,2'd1,2'd0,2'd0,2'd0,8'h10,32'h1234_5678),
                exp_rdy_edge:5'd3, exp_slverr:1'b0, exp_rdata:32'h0};
    // 2: timeout (T=8): pready at setup+10 (edge 9), late response at edge 14 ignored
    vecs[2] = '{dut_b:1'b0, write:1'b0, addr:16'h0755, wdata:32'h0,
                e0:5'd14, e1:NONE, e2:NONE, e3:NONE,
                p0:pk(1,1,0,2'd0,2'd0,2'd3,2'd1,8'h55,32'h9999_9999), p1:'0, p2:'0, p3:'0,
                exp_pkt:pk(1,0,0,2'd3,2'd1,2'd0,2'd0,8'h55,32'h0),
                exp_rdy_edge:5'd9, exp_slverr:1'b1, exp_rdata:32'h0};
    // 3: filtering: wrong src, request packet, wrong dst, then the match
    vecs[3] = '{dut_b:1'b0, write:1'b0, addr:16'h067C, wdata:32'h0,
                e0:5'd2, e1:5'd3, e2:5'd4, e3:5'd5,
                p0:pk(1,1,0,2'd0,2'd0,2'd1,2'd3,8'h7C,32'h1111_1111),
                p1:pk(1,0,0,2'd0,2'd0,2'd2,2'd1,8'h7C,32'h2222_2222),
                p2:pk(1,1,0,2'd0,2'd1,2'd2,2'd1,8'h7C,32'h3333_3333),
                p3:pk(1,1,0,2'd0,2'd0,2'd2,2'd1,8'h7C,32'hCAFE_F00D),
                exp_pkt:pk(1,0,0,2'd2,2'd1,2'd0,2'd0,8'h7C,32'h0),
                exp_rdy_edge:5'd5, exp_slverr:1'b0, exp_rdata:32'hCAFE_F00D};
    // 4: match in the timeout cycle wins
    vecs[4] = '{dut_b:1'b0, write:1'b0, addr:16'h0512, wdata:32'h0,
                e0:5'd9, e1:NONE, e2:NONE, e3:NONE,
                p0:pk(1,1,0,2'd0,2'd0,2'd1,2'd1,8'h12,32'h5A5A_5A5A), p1:'0, p2:'0, p3:'0,
                exp_pkt:pk(1,0,0,2'd1,2'd1,2'd0,2'd0,8'h12,32'h0),
                exp_rdy_edge:5'd9, exp_slverr:1'b0, exp_rdata:32'h5A5A_5A5A};
    // 5: grid 3, dstX=3: no packet, pready right after setup, response ignored
    vecs[5] = '{dut_b:1'b1, write:1'b0, addr:16'h0320, wdata:32'h0,
                e0:5'd3, e1:NONE, e2:NONE, e3:NONE,
                p0:pk(1,1,0,2'd0,2'd0,2'd3,2'd0,8'h20,32'h7777_7777), p1:'0, p2:'0, p3:'0,
                exp_pkt:'0,
                exp_rdy_edge:5'd0, exp_slverr:1'b1, exp_rdata:32'h0};
    // 6: grid 3 in-range read
    vecs[6] = '{dut_b:1'b1, write:1'b0, addr:16'h0A34, wdata:32'h0,
                e0:5'd2, e1:NONE, e2:NONE, e3:NONE,
                p0:pk(1,1,0,2'd0,2'd0,2'd2,2'd2,8'h34,32'h0BAD_CAFE), p1:'0, p2:'0, p3:'0,
                exp_pkt:pk(1,0,0,2'd2,2'd2,2'd0,2'd0,8'h34,32'h0),
                exp_rdy_edge:5'd2, exp_slverr:1'b0, exp_rdata:32'h0BAD_CAFE};
    // 7: write to own node is still sent into the network
    vecs[7] = '{dut_b:1'b0, write:1'b1, addr:16'h00F0, wdata:32'hA5A5_A5A5,
                e0:5'd2, e1:NONE, e2:NONE, e3:NONE,
                p0:pk(1,1,1,2'd0,2'd0,2'd0,2'd0,8'hF0,32'h0), p1:'0, p2:'0, p3:'0,
                exp_pkt:pk(1,0,1,2'd0,2'd0,2'd0,2'd0,8'hF0,32'hA5A5_A5A5),
                exp_rdy_edge:5'd2, exp_slverr:1'b0, exp_rdata:32'h0};

    sel = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; rsp = '0;
    rst = 1'b1;
    idle_cycles(3);
    exp_q.push_back(64'd0); chk("rst_pready", 64'(a_if.o_pready));
    exp_q.push_back(64'd0); chk("rst_pslverr", 64'(a_if.o_pslverr));
    exp_q.push_back(64'd0); chk("rst_prdata", 64'(a_if.o_prdata));
    exp_q.push_back(64'd0); chk("rst_pkt", 64'(a_if.o_niToRouter));
    exp_q.push_back(64'd0); chk("rst_state_a", 64'(a_dbg));
    exp_q.push_back(64'd0); chk("rst_state_b", 64'(b_dbg));
    rst = 1'b0;
    idle_cycles(2);

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // Reset during WAIT aborts the access and the late response is ignored.
    begin
      int rdy_cnt;
      rdy_cnt = 0;
      sel = 1'b0; psel = 1'b1; penable = 1'b0; pwrite = 1'b0;
      paddr = 16'h0A34; pwdata = '0;
      @(posedge clk); @(negedge clk);
      penable = 1'b1;
      exp_q.push_back(64'd1); chk("rst_seq_send_state", 64'(a_dbg));
      @(posedge clk); @(negedge clk);
      exp_q.push_back(64'd2); chk("rst_seq_wait_state", 64'(a_dbg));
      rst = 1'b1;
      #1;
      exp_q.push_back(64'd0); chk("rst_seq_state", 64'(a_dbg));
      exp_q.push_back(64'd0); chk("rst_seq_pready", 64'(a_if.o_pready));
      exp_q.push_back(64'd0); chk("rst_seq_pkt", 64'(a_if.o_niToRouter));
      @(negedge clk);
      rst = 1'b0; psel = 1'b0; penable = 1'b0;
      rsp = pk(1,1,0,2'd0,2'd0,2'd2,2'd2,8'h34,32'h1357_9BDF);
      @(negedge clk);
      rsp = '0;
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        if (a_if.o_pready) rdy_cnt++;
      end
      exp_q.push_back(64'd0); chk("rst_seq_late_pready", 64'(rdy_cnt));
      exp_q.push_back(64'd0); chk("rst_seq_idle_state", 64'(a_dbg));
    end

    // A normal read after the aborted access.
    run_vec(8, vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ni_apb_initiator.md
# ni_apb_initiator

Initiator-side network interface for one mesh node. It accepts a single APB transaction from the local APB requester and converts it into a request packet on the node's router port. It then waits for the matching response packet and completes the APB access with read data, or with an error on timeout. It drives the `i_niToRouter` slot of its node on the `noc` top and consumes the corresponding `o_routerToNi` slot. Request packets addressed to this node are served by the target-side NI, not by this block.

## Interface
- GRID_WIDTH, 4: mesh dimension. Must be ≥2. CW = $clog2(GRID_WIDTH).
- NODE_X, 0: this node's X coordinate.
- NODE_Y, 0: this node's Y coordinate.
- TIMEOUT_CYCLES, 64: number of WAIT cycles without a match before the access is errored. Must be ≥1.
- i_clk  in  1  clock.
- i_arst  in  1  asynchronous reset, active-high.
- i_psel, i_penable, i_pwrite  in  1 each  APB completer controls.
- i_paddr  in  16  bits [7:0] are the local address, [8+CW-1:8] are dstX, [8+2CW-1:8+CW] are dstY. Higher bits are ignored.
- i_pwdata  in  32  write data.
- o_pready, o_pslverr  out  1 each  APB completion.
- o_prdata  out  32  read data.
- o_niToRouter  out  APB_PACKET_WIDTH  packet to the router.
- i_routerToNi  in  APB_PACKET_WIDTH  packet from the router.
- Packet layout, MSB first: valid, isResp, write, dstX[CW], dstY[CW], srcX[CW], srcY[CW], addr[8], data[32]. Width = 43 + 4·CW (51 for GRID_WIDTH = 4).

## Operation
The block is controlled by an FSM with four states: IDLE, SEND, WAIT and DONE.
- **IDLE:** on i_psel=1 and i_penable=0 (setup phase), capture pwrite, the address fields and pwdata.
  - If dstX ≥ GRID_WIDTH or dstY ≥ GRID_WIDTH, go to DONE with the error flag set and send no packet.
  - Otherwise go to SEND.
- **SEND:** o_niToRouter holds the request packet for exactly one cycle:
  - valid=1, isResp=0, write=captured pwrite.
  - dst = captured dstX/dstY; src = NODE_X/NODE_Y.
  - addr = paddr[7:0]; data = pwdata for writes, 0 for reads.
  - Next state is WAIT. A destination equal to the own node is still sent into the network.
- **WAIT:** a packet on i_routerToNi matches when all of these hold:
  - valid=1 and isResp=1;
  - dst = (NODE_X, NODE_Y);
  - src = captured destination.
  - On a match, latch data into the read-data register (writes latch 0), clear the error flag and go to DONE.
  - Non-matching packets are ignored.
  - The timeout counter (width $clog2(TIMEOUT_CYCLES+1)) clears on entry to WAIT and increments on each WAIT cycle without a match. When it equals TIMEOUT_CYCLES-1 with no match, set the error flag, set read data to 0 and go to DONE.
  - If a match arrives in the same cycle as the timeout, the match wins.
- **DONE:** o_pready=1 for one cycle, with o_prdata and o_pslverr valid in that same cycle. Next state is IDLE.
- **Outside DONE:** o_pready, o_pslverr and o_prdata are 0.
- **Outside SEND:** o_niToRouter is all-zero.
- Once captured, the transaction always runs to DONE, even if i_psel drops. The access phase (i_penable=1) is not checked.
- Responses arriving in IDLE, SEND or DONE are ignored. This includes late responses after a timeout.

## Timing
- All outputs are registered.
- **Reset:** state IDLE, timeout counter 0, all outputs 0. Asserting reset mid-transaction aborts it: no o_pready is produced and a later response is ignored.
- **Request packet:** setup phase sampled at edge 0 → packet valid during cycle 1 only.
- **Completion:** match sampled at edge k → o_pready high during cycle k+1. Minimum read latency from setup to pready is 3 cycles when the response arrives in the first WAIT cycle.
- **Timeout:** o_pready rises TIMEOUT_CYCLES+2 cycles after the setup edge.
- **Bad address:** o_pready rises 1 cycle after the setup edge with pslverr=1.
- **Back-to-back:** a new setup phase is accepted in IDLE, i.e. the cycle after DONE at the earliest.

## Test plan
- **Read:** NODE=(0,0), GRID_WIDTH=4, paddr=0x0A34 (dstX=2, dstY=2, addr=0x34). Expect one valid packet with dst=(2,2), src=(0,0), write=0. Inject response {isResp=1, dst=(0,0), src=(2,2), data=0xDEADBEEF} two cycles later. Expect pready for one cycle, prdata=0xDEADBEEF, pslverr=0.
- **Write:** paddr=0x0110, pwdata=0x12345678. Expect packet data=0x12345678 and write=1. After the response, expect pready, pslverr=0, prdata=0.
- **Timeout:** TIMEOUT_CYCLES=8, no response. Expect pready with pslverr=1 and prdata=0 at setup+10. A response injected at setup+15 must produce no second pready.
- **Filtering:** during WAIT, inject a response with the wrong src (1,3), then a request packet (isResp=0), then the correct response. Expect exactly one pready, carrying the correct data.
- **Bad address:** GRID_WIDTH=3, dstX=3. Expect no packet and pready with pslverr=1 one cycle after setup.
- **Reset in WAIT:** assert i_arst during WAIT. Expect all outputs 0 immediately, and a later matching response is ignored. A subsequent read completes normally.
